// File: rtl/hispi_pattern_tx.sv
// HiSPi Packetized-SP single-lane pattern transmitter (SOF/SOL/EOL/EOF framing).
// Optional HISPI_TX_LINE_NUM_EN: adds a line-number word after each SOF/SOL.
module hispi_pattern_tx #(
    parameter int PIXEL_WIDTH = 12,
    parameter int WIDTH_BITS  = 13,
    parameter int LINES_BITS  = 12,
    parameter int BLANK_BITS  = 8
) (
    input  logic                   sclk,
    input  logic                   sclk_reset_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic [LINES_BITS-1:0]  cfg_num_lines,
    input  logic [WIDTH_BITS-1:0]  cfg_line_width,
    input  logic [BLANK_BITS-1:0]  cfg_blank,
    input  logic                   cfg_pattern,
    input  logic [PIXEL_WIDTH-1:0] cfg_const,
    output logic [PIXEL_WIDTH-1:0] tx_data,
    output logic                   tx_valid,
    output logic                   tx_busy,
    output logic                   frame_done
);

    localparam int CW0 = (WIDTH_BITS > BLANK_BITS) ? WIDTH_BITS : BLANK_BITS;
    localparam int CW  = (CW0 < 3) ? 3 : CW0;

`ifdef HISPI_TX_LINE_NUM_EN
    localparam int SS_LAST = 4;
`else
    localparam int SS_LAST = 3;
`endif

    localparam logic [PIXEL_WIDTH-1:0] ONES = '1;
    localparam logic [PIXEL_WIDTH-1:0] SOF  = {3'b110, {(PIXEL_WIDTH-3){1'b0}}};
    localparam logic [PIXEL_WIDTH-1:0] SOL  = {3'b100, {(PIXEL_WIDTH-3){1'b0}}};
    localparam logic [PIXEL_WIDTH-1:0] EOF  = {3'b111, {(PIXEL_WIDTH-3){1'b0}}};
    localparam logic [PIXEL_WIDTH-1:0] EOL  = {3'b101, {(PIXEL_WIDTH-3){1'b0}}};

    typedef enum logic [2:0] {
        IDLE,
        SYNC_START,
        PIXELS,
        SYNC_END,
        BLANK
    } state_t;

    state_t                 state, n_state;
    logic [CW-1:0]          cnt, n_cnt;
    logic [LINES_BITS-1:0]  y, n_y;
    logic                   done;

    logic [LINES_BITS-1:0]  lines_q;
    logic [WIDTH_BITS-1:0]  width_q;
    logic [BLANK_BITS-1:0]  blank_q;
    logic                   pattern_q;
    logic [PIXEL_WIDTH-1:0] const_q;

    logic                   accept;
    logic [LINES_BITS-1:0]  lines_last;
    logic [CW-1:0]          width_last;
    logic [CW-1:0]          blank_last;

    logic [PIXEL_WIDTH-1:0] d_data;
    logic                   d_valid;

    function automatic logic [PIXEL_WIDTH-1:0] clamp(
        input logic [PIXEL_WIDTH-1:0] v
    );
        return (v == ONES) ? ONES - 1'b1 : v;
    endfunction

    assign accept     = (state == IDLE) && start && !abort
                      && (cfg_num_lines != '0);
    assign lines_last = lines_q - LINES_BITS'(1);
    assign width_last = CW'(width_q) - CW'(1);
    assign blank_last = CW'(blank_q) - CW'(1);

    always_comb begin
        n_state = state;
        n_cnt   = cnt;
        n_y     = y;
        done    = 1'b0;
        if (abort) begin
            n_state = IDLE;
            n_cnt   = '0;
            n_y     = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        n_state = SYNC_START;
                        n_cnt   = '0;
                        n_y     = '0;
                    end
                end
                SYNC_START: begin
                    if (cnt == CW'(SS_LAST)) begin
                        n_cnt   = '0;
                        n_state = (width_q == '0) ? SYNC_END : PIXELS;
                    end else begin
                        n_cnt = cnt + CW'(1);
                    end
                end
                PIXELS: begin
                    if (cnt == width_last) begin
                        n_cnt   = '0;
                        n_state = SYNC_END;
                    end else begin
                        n_cnt = cnt + CW'(1);
                    end
                end
                SYNC_END: begin
                    if (cnt == CW'(3)) begin
                        n_cnt = '0;
                        if (y == lines_last) begin
                            n_state = IDLE;
                            n_y     = '0;
                            done    = 1'b1;
                        end else begin
                            n_y     = y + LINES_BITS'(1);
                            n_state = (blank_q != '0) ? BLANK : SYNC_START;
                        end
                    end else begin
                        n_cnt = cnt + CW'(1);
                    end
                end
                BLANK: begin
                    if (cnt == blank_last) begin
                        n_cnt   = '0;
                        n_state = SYNC_START;
                    end else begin
                        n_cnt = cnt + CW'(1);
                    end
                end
                default: begin
                    n_state = IDLE;
                    n_cnt   = '0;
                    n_y     = '0;
                end
            endcase
        end
    end

    // Output word is derived from the upcoming state so that it lands registered.
    always_comb begin
        d_data  = '0;
        d_valid = 1'b0;
        unique case (n_state)
            SYNC_START: begin
                d_valid = 1'b1;
                if (n_cnt == '0)
                    d_data = ONES;
                else if (n_cnt == CW'(3))
                    d_data = (n_y == '0) ? SOF : SOL;
`ifdef HISPI_TX_LINE_NUM_EN
                else if (n_cnt == CW'(4))
                    d_data = clamp(PIXEL_WIDTH'(n_y));
`endif
            end
            PIXELS: begin
                d_valid = 1'b1;
                if (pattern_q)
                    d_data = clamp(const_q);
                else
                    d_data = clamp(PIXEL_WIDTH'(n_cnt) + PIXEL_WIDTH'(n_y));
            end
            SYNC_END: begin
                d_valid = 1'b1;
                if (n_cnt == '0)
                    d_data = ONES;
                else if (n_cnt == CW'(3))
                    d_data = (n_y == lines_last) ? EOF : EOL;
            end
            default: begin
                d_data  = '0;
                d_valid = 1'b0;
            end
        endcase
    end

    always_ff @(posedge sclk or negedge sclk_reset_n) begin
        if (!sclk_reset_n) begin
            state      <= IDLE;
            cnt        <= '0;
            y          <= '0;
            lines_q    <= '0;
            width_q    <= '0;
            blank_q    <= '0;
            pattern_q  <= 1'b0;
            const_q    <= '0;
            tx_data    <= '0;
            tx_valid   <= 1'b0;
            tx_busy    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= n_state;
            cnt        <= n_cnt;
            y          <= n_y;
            tx_data    <= d_data;
            tx_valid   <= d_valid;
            tx_busy    <= (n_state != IDLE);
            frame_done <= done;
            if (accept) begin
                lines_q   <= cfg_num_lines;
                width_q   <= cfg_line_width;
                blank_q   <= cfg_blank;
                pattern_q <= cfg_pattern;
                const_q   <= cfg_const;
            end
        end
    end

endmodule

// File: tb/tb_hispi_pattern_tx.sv
// Self-checking bench for hispi_pattern_tx against a frame-level word model.
// Define HISPI_TX_LINE_NUM_EN for both DUT and bench to cover the line-number word.
module tb_hispi_pattern_tx;

    logic        sclk = 1'b0;
    logic        sclk_reset_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [11:0] cfg_num_lines = '0;
    logic [12:0] cfg_line_width = '0;
    logic [7:0]  cfg_blank = '0;
    logic        cfg_pattern = 1'b0;
    logic [11:0] cfg_const = '0;
    logic [11:0] tx_data;
    logic        tx_valid;
    logic        tx_busy;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    bit          exp_v[$];
    logic [11:0] exp_d[$];

`ifdef HISPI_TX_LINE_NUM_EN
    localparam int LNUM = 1;
`else
    localparam int LNUM = 0;
`endif

    hispi_pattern_tx dut (
        .sclk           (sclk),
        .sclk_reset_n   (sclk_reset_n),
        .start          (start),
        .abort          (abort),
        .cfg_num_lines  (cfg_num_lines),
        .cfg_line_width (cfg_line_width),
        .cfg_blank      (cfg_blank),
        .cfg_pattern    (cfg_pattern),
        .cfg_const      (cfg_const),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_busy        (tx_busy),
        .frame_done     (frame_done)
    );

    always #5 sclk = ~sclk;

    function automatic logic [11:0] clampv(int v);
        logic [11:0] w;
        w = v[11:0];
        return (w == 12'hFFF) ? 12'hFFE : w;
    endfunction

    function automatic void push(bit v, logic [11:0] d);
        exp_v.push_back(v);
        exp_d.push_back(d);
    endfunction

    // Whole frame as the receiver should see it, one entry per cycle.
    function automatic void build(int lines, int width, int blank,
                                  bit pat, logic [11:0] k);
        exp_v.delete();
        exp_d.delete();
        for (int yy = 0; yy < lines; yy++) begin
            push(1, 12'hFFF); push(1, 12'h000); push(1, 12'h000);
            push(1, (yy == 0) ? 12'hC00 : 12'h800);
            if (LNUM != 0) push(1, clampv(yy));
            for (int xx = 0; xx < width; xx++)
                push(1, pat ? clampv(int'(k)) : clampv((xx + yy) % 4096));
            push(1, 12'hFFF); push(1, 12'h000); push(1, 12'h000);
            push(1, (yy == lines - 1) ? 12'hE00 : 12'hA00);
            if (yy < lines - 1)
                for (int b = 0; b < blank; b++) push(0, 12'h000);
        end
    endfunction

    task automatic scramble_cfg();
        cfg_num_lines  = 12'($urandom_range(0, 7));
        cfg_line_width = 13'($urandom_range(0, 31));
        cfg_blank      = 8'($urandom_range(0, 9));
        cfg_pattern    = 1'($urandom);
        cfg_const      = 12'($urandom);
    endtask

    task automatic run_frame(string name, int lines, int width, int blank,
                             bit pat, logic [11:0] k, int inject);
        int busy_cnt;
        int expect_len;
        busy_cnt   = 0;
        expect_len = lines * (8 + width + LNUM) + (lines - 1) * blank;
        build(lines, width, blank, pat, k);
        cfg_num_lines  = 12'(lines);
        cfg_line_width = 13'(width);
        cfg_blank      = 8'(blank);
        cfg_pattern    = pat;
        cfg_const      = k;
        start = 1'b1;
        @(posedge sclk); #1;
        start = 1'b0;
        scramble_cfg();
        for (int i = 0; i < exp_v.size(); i++) begin
            if (i == inject) start = 1'b1;
            checks++;
            if (tx_valid !== exp_v[i] || tx_data !== exp_d[i] ||
                frame_done !== 1'b0) begin
                errors++;
                $display("FAIL %s word %0d: got valid=%b data=%h done=%b, expected valid=%b data=%h done=0",
                         name, i, tx_valid, tx_data, frame_done, exp_v[i], exp_d[i]);
            end
            if (tx_busy === 1'b1) busy_cnt++;
            @(posedge sclk); #1;
            start = 1'b0;
        end
        checks++;
        if (frame_done !== 1'b1 || tx_busy !== 1'b0 || tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s end: got done=%b busy=%b valid=%b, expected done=1 busy=0 valid=0",
                     name, frame_done, tx_busy, tx_valid);
        end
        checks++;
        if (busy_cnt != expect_len) begin
            errors++;
            $display("FAIL %s busy_len: got %0d cycles, expected %0d",
                     name, busy_cnt, expect_len);
        end
    endtask

    task automatic check_idle(string name);
        checks++;
        if (tx_valid !== 1'b0 || tx_data !== 12'h000 || tx_busy !== 1'b0 ||
            frame_done !== 1'b0) begin
            errors++;
            $display("FAIL %s: got valid=%b data=%h busy=%b done=%b, expected all zero",
                     name, tx_valid, tx_data, tx_busy, frame_done);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge sclk);
        #1;
        check_idle("reset");
        sclk_reset_n = 1'b1;
        @(posedge sclk); #1;
        check_idle("after_reset");
    endtask

    task automatic test_ramp();
        run_frame("ramp_2x4", 2, 4, 3, 1'b0, 12'h000, -1);
        @(posedge sclk); #1;
        check_idle("ramp_done_pulse_width");
    endtask

    task automatic test_const_clamp();
        run_frame("const_fff", 1, 2, 0, 1'b1, 12'hFFF, -1);
        run_frame("const_5a5", 2, 3, 1, 1'b1, 12'h5A5, -1);
    endtask

    task automatic test_zero_width();
        run_frame("zero_width", 3, 0, 0, 1'b0, 12'h000, -1);
    endtask

    task automatic test_ignored_starts();
        run_frame("restart_mid", 2, 5, 2, 1'b0, 12'h000, 7);
        cfg_num_lines = '0;
        start = 1'b1;
        @(posedge sclk); #1;
        start = 1'b0;
        check_idle("start_lines0");
        @(posedge sclk); #1;
        check_idle("start_lines0_hold");
    endtask

    task automatic test_abort();
        cfg_num_lines  = 12'd2;
        cfg_line_width = 13'd4;
        cfg_blank      = 8'd3;
        cfg_pattern    = 1'b0;
        start = 1'b1;
        @(posedge sclk); #1;
        start = 1'b0;
        repeat (5) begin
            @(posedge sclk); #1;
        end
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== 12'h001) begin
            errors++;
            $display("FAIL abort_pre: got valid=%b data=%h, expected valid=1 data=001",
                     tx_valid, tx_data);
        end
        abort = 1'b1;
        start = 1'b1;
        @(posedge sclk); #1;
        abort = 1'b0;
        start = 1'b0;
        check_idle("abort_next");
        for (int i = 0; i < 4; i++) begin
            @(posedge sclk); #1;
            check_idle("abort_quiet");
        end
        run_frame("after_abort", 2, 4, 3, 1'b0, 12'h000, -1);
    endtask

    task automatic test_reset_mid();
        cfg_num_lines  = 12'd3;
        cfg_line_width = 13'd10;
        cfg_blank      = 8'd2;
        start = 1'b1;
        @(posedge sclk); #1;
        start = 1'b0;
        repeat (7) @(posedge sclk);
        #2;
        sclk_reset_n = 1'b0;
        #1;
        check_idle("reset_mid_async");
        sclk_reset_n = 1'b1;
        @(posedge sclk); #1;
        check_idle("reset_mid_release");
        run_frame("after_reset_mid", 2, 3, 1, 1'b0, 12'h000, -1);
    endtask

    task automatic test_line_num();
        run_frame("line_num_2x1", 2, 1, 0, 1'b0, 12'h000, -1);
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 10; n++) begin
            int          l;
            int          w;
            int          b;
            bit          p;
            logic [11:0] k;
            l = $urandom_range(1, 4);
            w = $urandom_range(0, 20);
            b = $urandom_range(0, 5);
            p = 1'($urandom);
            k = ($urandom_range(0, 3) == 0) ? 12'hFFF : 12'($urandom);
            run_frame("random", l, w, b, p, k,
                      ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 8)) : -1);
        end
    endtask

    task automatic test_ramp_wrap();
        run_frame("ramp_wrap", 2, 4097, 1, 1'b0, 12'h000, -1);
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_const_clamp();
        test_zero_width();
        test_ignored_starts();
        test_abort();
        test_reset_mid();
        test_line_num();
        test_back_to_back();
        test_ramp_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hispi_pattern_tx.md
Name: hispi_pattern_tx

Overview:
- Synthesizable HiSPi Packetized-SP single-lane word transmitter. It emits sensor-style frames (sync codes plus pixel words) on a parallel lane word.
- Acts as the sensor-side counterpart to the Athena HiSPi receive path. Used as an in-FPGA pattern source so the XGS validation tests can drive the receiver without the sensor model.
- One frame per start request; every frame parameter is sampled at start.

Parameters:
- PIXEL_WIDTH, 12, lane word / pixel width in bits (min 10).
- WIDTH_BITS, 13, width of line-length counter (max 8191 pixels).
- LINES_BITS, 12, width of line counter.
- BLANK_BITS, 8, width of inter-line blanking counter.

Ports:
- sclk  in  1  system clock.
- sclk_reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle frame request.
- abort  in  1  synchronous abort; highest priority.
- cfg_num_lines  in  LINES_BITS  lines per frame.
- cfg_line_width  in  WIDTH_BITS  pixels per line.
- cfg_blank  in  BLANK_BITS  idle cycles between lines.
- cfg_pattern  in  1  0 = ramp, 1 = constant.
- cfg_const  in  PIXEL_WIDTH  value used in constant mode.
- tx_data  out  PIXEL_WIDTH  lane word.
- tx_valid  out  1  tx_data meaningful.
- tx_busy  out  1  frame in progress.
- frame_done  out  1  one-cycle pulse at frame end.

Behaviour:
- Reset (async, sclk_reset_n=0):
  - state=IDLE.
  - tx_data=0, tx_valid=0, tx_busy=0, frame_done=0.
  - All counters and configuration shadow registers cleared.
- All outputs are registered.
- Sync code is 4 words: all-ones (0xFFF), 0x000, 0x000, TYPE.
- TYPE is written for 12-bit words and is left-aligned for other widths:
  - SOF = 0xC00.
  - SOL = 0x800.
  - EOF = 0xE00.
  - EOL = 0xA00.
- States: IDLE, SYNC_START, PIXELS, SYNC_END, BLANK.
- IDLE:
  - start=1 and cfg_num_lines!=0: latch all cfg_*, set y=0, go to SYNC_START. tx_busy=1 from the next cycle.
  - First sync word appears on the cycle after start (latency 1).
  - start with cfg_num_lines=0 is ignored.
  - start while tx_busy=1 is ignored.
- SYNC_START:
  - 4 cycles, tx_valid=1.
  - TYPE = SOF if y==0, else SOL.
  - Then go to PIXELS, or to SYNC_END if width==0.
- PIXELS:
  - width cycles, tx_valid=1, pixel index x = 0..width-1.
  - Ramp mode: value = (x + y) mod 2^PIXEL_WIDTH.
  - Constant mode: value = cfg_const.
  - Any pixel value equal to all-ones is clamped to all-ones minus 1 (0xFFE), so pixel data never aliases a sync start.
- SYNC_END:
  - 4 cycles, tx_valid=1.
  - TYPE = EOF if y==lines-1, else EOL.
  - After EOF: go to IDLE, frame_done=1 for one cycle and tx_busy=0 in that same cycle.
  - After EOL: increment y; go to BLANK if blank!=0, else straight to SYNC_START.
- BLANK:
  - blank cycles, tx_valid=0, tx_data=0.
  - Then go to SYNC_START.
- No blanking is inserted after the last line.
- abort=1 in any state:
  - Next cycle: state=IDLE, tx_valid=0, tx_data=0, tx_busy=0.
  - No frame_done.
  - abort takes priority over a simultaneous start.
- Reset asserted mid-frame: immediate return to reset values; no partial sync completion.
- Counter wrap: y and x never wrap inside a frame, because their widths are matched to the cfg widths.
- Total cycles per frame (valid plus blank) = lines*(8+width) + (lines-1)*blank.

Optional Feature:
- Macro: HISPI_TX_LINE_NUM_EN.
- Defined:
  - One extra word is inserted after every SOF/SOL sync, before the pixels, with tx_valid=1.
  - The word is y zero-extended to PIXEL_WIDTH; the all-ones clamp applies.
  - Frame length grows by lines cycles.
- Not defined: no extra word; timing exactly as in Behaviour.

Test Plan:
- Reset, then start with lines=2, width=4, blank=3, ramp -> words FFF,000,000,C00, 000,001,002,003, FFF,000,000,A00; then 3 idle cycles; then FFF,000,000,800, 001,002,003,004, FFF,000,000,E00; frame_done on the following cycle; tx_busy high for exactly 27 cycles.
- Constant mode, cfg_const=0xFFF, lines=1, width=2 -> pixels 0xFFE,0xFFE; SOF then EOF; frame_done pulse.
- width=0, lines=3, blank=0 -> per line only 8 sync words (SOF/EOL, SOL/EOL, SOL/EOF), no valid gaps; 24 valid cycles.
- start pulsed again mid-frame, and start with lines=0 in IDLE -> both ignored; the first frame completes unchanged.
- abort on the 2nd pixel of line 0 while start is also high -> next cycle tx_valid=0, tx_busy=0, no frame_done; a new start afterwards produces a full SOF frame.
- With HISPI_TX_LINE_NUM_EN defined, lines=2, width=1 -> word 0x000 after SOF and 0x001 after SOL; frame is 2 cycles longer than the undefined build.
